// File: rtl/status_flag_unit_if.sv
// Bus bundle for status_flag_unit: EXE-stage flag update, shadow save/restore
// controls and the NZCV views returned to the pipeline.
interface status_flag_unit_if;
  logic       freeze;
  logic       s_update;
  logic [3:0] flag_mask;
  logic [3:0] alu_status;
  logic       save;
  logic       restore;
  logic [3:0] status_out;
  logic [3:0] status_fwd;
  logic       shadow_valid;
  logic       flags_pending;

  modport master (
    output freeze, s_update, flag_mask, alu_status, save, restore,
    input  status_out, status_fwd, shadow_valid, flags_pending
  );

  modport slave (
    input  freeze, s_update, flag_mask, alu_status, save, restore,
    output status_out, status_fwd, shadow_valid, flags_pending
  );
endinterface

// File: rtl/status_flag_unit.sv
// Architectural NZCV register with masked EXE update and a one-entry shadow.
// Define STATUS_FLAG_FWD_EN to bypass the pending update to ID instead of stalling.
module status_flag_unit (
  input  logic               clk,
  input  logic               rst,
  status_flag_unit_if.slave  bus
);

  logic [3:0] nzcv_q, nzcv_d;
  logic [3:0] shadow_q, shadow_d;
  logic       shadow_valid_q, shadow_valid_d;

  logic       wr;
  logic       save_ok;
  logic       restore_ok;
  logic [3:0] masked_upd;

  always_comb begin
    wr         = bus.s_update & ~bus.freeze;
    save_ok    = bus.save & ~bus.freeze;
    restore_ok = bus.restore & shadow_valid_q & ~bus.freeze;
    masked_upd = (bus.alu_status & bus.flag_mask) | (nzcv_q & ~bus.flag_mask);
  end

  // Restore wins over the EXE update; save always captures the pre-edge nzcv,
  // which makes a simultaneous save+restore a swap that keeps the shadow valid.
  always_comb begin
    nzcv_d         = nzcv_q;
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    if (restore_ok) begin
      nzcv_d         = shadow_q;
      shadow_valid_d = 1'b0;
    end else if (wr) begin
      nzcv_d = masked_upd;
    end
    if (save_ok) begin
      shadow_d       = nzcv_q;
      shadow_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nzcv_q         <= 4'b0000;
      shadow_q       <= 4'b0000;
      shadow_valid_q <= 1'b0;
    end else begin
      nzcv_q         <= nzcv_d;
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
    end
  end

  assign bus.status_out   = nzcv_q;
  assign bus.shadow_valid = shadow_valid_q;

`ifdef STATUS_FLAG_FWD_EN
  assign bus.status_fwd    = nzcv_d;
  assign bus.flags_pending = 1'b0;
`else
  assign bus.status_fwd    = nzcv_q;
  assign bus.flags_pending = wr | restore_ok;
`endif

endmodule

// File: tb/tb_status_flag_unit.sv
// Self-checking bench for status_flag_unit: directed scenarios with literal
// expectations followed by randomized traffic compared against a flag model.
module tb_status_flag_unit;

  logic clk;
  logic rst;
  status_flag_unit_if bus ();

  status_flag_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: the architectural flags, the saved copy, and whether
  // an exception entry is still outstanding.
  bit [3:0] m_flags;
  bit [3:0] m_saved;
  bit       m_saved_live;

  function automatic bit [3:0] merge_flags(input bit [3:0] cur, input bit [3:0] alu,
                                           input bit [3:0] mask);
    bit [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = mask[i] ? alu[i] : cur[i];
    return r;
  endfunction

  function automatic bit [3:0] flags_after_edge();
    bit active;
    active = !bus.freeze;
    if (active && bus.restore && m_saved_live) return m_saved;
    if (active && bus.s_update) return merge_flags(m_flags, bus.alu_status, bus.flag_mask);
    return m_flags;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_flags      = 4'b0000;
      m_saved      = 4'b0000;
      m_saved_live = 1'b0;
    end else begin
      bit [3:0] old_flags;
      bit       did_restore;
      old_flags   = m_flags;
      did_restore = !bus.freeze && bus.restore && m_saved_live;
      m_flags     = flags_after_edge();
      if (!bus.freeze && bus.save) begin
        m_saved      = old_flags;
        m_saved_live = 1'b1;
      end else if (did_restore) begin
        m_saved_live = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] actual,
                             input logic [3:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle out of reset, all four outputs must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      bit [3:0] exp_fwd;
      bit       exp_pend;
      bit       w;
      bit       r;
      w = bus.s_update && !bus.freeze;
      r = bus.restore && m_saved_live && !bus.freeze;
`ifdef STATUS_FLAG_FWD_EN
      exp_fwd  = flags_after_edge();
      exp_pend = 1'b0;
`else
      exp_fwd  = m_flags;
      exp_pend = w || r;
`endif
      checkOutput("cyc_status_out", bus.status_out, m_flags);
      checkOutput("cyc_shadow_valid", {3'b0, bus.shadow_valid}, {3'b0, m_saved_live});
      checkOutput("cyc_status_fwd", bus.status_fwd, exp_fwd);
      checkOutput("cyc_flags_pending", {3'b0, bus.flags_pending}, {3'b0, exp_pend});
    end
  end

  task automatic applyStimulus(input bit s_upd, input bit [3:0] mask, input bit [3:0] alu,
                               input bit sv, input bit rs, input bit frz);
    @(posedge clk);
    #1;
    bus.s_update   = s_upd;
    bus.flag_mask  = mask;
    bus.alu_status = alu;
    bus.save       = sv;
    bus.restore    = rs;
    bus.freeze     = frz;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.s_update   = 1'b0;
    bus.flag_mask  = 4'b0000;
    bus.alu_status = 4'b0000;
    bus.save       = 1'b0;
    bus.restore    = 1'b0;
    bus.freeze     = 1'b0;
    #2;
    checkOutput("reset_status_out", bus.status_out, 4'b0000);
    checkOutput("reset_status_fwd", bus.status_fwd, 4'b0000);
    checkOutput("reset_pending", {3'b0, bus.flags_pending}, 4'b0000);
    checkOutput("reset_shadow_valid", {3'b0, bus.shadow_valid}, 4'b0000);
    #20;
    rst = 1'b0;

    // Masked update then all-zero mask no-op.
    applyStimulus(1'b1, 4'b1100, 4'b1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    checkOutput("masked_update", bus.status_out, 4'b1100);
    idle();
    checkOutput("zero_mask_noop", bus.status_out, 4'b1100);

    // Freeze holds state.
    applyStimulus(1'b1, 4'b1111, 4'b0101, 1'b0, 1'b0, 1'b1);
`ifdef STATUS_FLAG_FWD_EN
    checkOutput("freeze_fwd", bus.status_fwd, 4'b1100);
`else
    checkOutput("freeze_pending", {3'b0, bus.flags_pending}, 4'b0000);
`endif
    idle();
    checkOutput("freeze_hold", bus.status_out, 4'b1100);

    // Save with update, restore, ignored second restore.
    applyStimulus(1'b1, 4'b1111, 4'b0110, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1111, 4'b1001, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("save_with_wr_nzcv", bus.status_out, 4'b1001);
    checkOutput("save_valid", {3'b0, bus.shadow_valid}, 4'b0001);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("restore_nzcv", bus.status_out, 4'b0110);
    checkOutput("restore_clears_valid", {3'b0, bus.shadow_valid}, 4'b0000);
    idle();
    checkOutput("second_restore_ignored", bus.status_out, 4'b0110);

    // Restore beats update; save+restore swaps.
    applyStimulus(1'b1, 4'b1111, 4'b1000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0);
    checkOutput("prio_pre_nzcv", bus.status_out, 4'b0001);
    idle();
    checkOutput("restore_beats_wr", bus.status_out, 4'b1000);
    applyStimulus(1'b1, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("swap_nzcv", bus.status_out, 4'b1000);
    checkOutput("swap_valid", {3'b0, bus.shadow_valid}, 4'b0001);
    idle();
    checkOutput("swap_shadow", bus.status_out, 4'b0001);

    // Forwarding vs stall behaviour.
    applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1111, 4'b0100, 1'b0, 1'b0, 1'b0);
`ifdef STATUS_FLAG_FWD_EN
    checkOutput("fwd_same_cycle", bus.status_fwd, 4'b0100);
    checkOutput("fwd_no_pending", {3'b0, bus.flags_pending}, 4'b0000);
`else
    checkOutput("nofwd_same_cycle", bus.status_fwd, 4'b0000);
    checkOutput("nofwd_pending", {3'b0, bus.flags_pending}, 4'b0001);
`endif
    idle();
    checkOutput("fwd_next_cycle", bus.status_fwd, 4'b0100);

    // Mid-cycle reset with full flags and a live shadow.
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
    idle();
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midreset_status_out", bus.status_out, 4'b0000);
    checkOutput("midreset_shadow_valid", {3'b0, bus.shadow_valid}, 4'b0000);
    rst = 1'b0;

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) begin
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rand_reset_status_out", bus.status_out, 4'b0000);
        rst = 1'b0;
      end
    end
    idle();
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
